// File: rtl/sram1_arb_pkg.sv
// rtl/sram1_arb_pkg.sv - shared state encoding and SRAM 1 window constants
package sram1_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    localparam logic [31:0] SRAM1_BASE = 32'h2000_0000;
    localparam logic [31:0] SRAM1_LAST = 32'h2001_7FFF;

    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] last
    );
        return (addr >= base) && (addr <= last);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-grant pointer
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant_valid,
    output logic       grant_port
);

    logic last_q;

    // On contention the port not granted last wins; pointer starts at 1 so port 0 wins first.
    always_comb begin
        grant_valid = |req;
        if (&req) begin
            grant_port = ~last_q;
        end else begin
            grant_port = req[1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (take && grant_valid) begin
            last_q <= grant_port;
        end
    end

endmodule

// File: rtl/sram1_arbiter.sv
// rtl/sram1_arbiter.sv - two-port arbiter in front of the single-port SRAM 1
module sram1_arbiter
    import sram1_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = SRAM1_BASE,
    parameter logic [31:0] LAST_ADDR = SRAM1_LAST
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    arb_state_t  state_q, state_d;
    logic        grant_valid, grant_port, take;
    logic        sel_we, sel_in_range;
    logic [31:0] sel_addr, sel_wdata;
    logic        gnt_port_q, we_q, in_range_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [31:0] resp_rdata;

    assign take = (state_q == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         ({p1_req, p0_req}),
        .take        (take),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign sel_we       = grant_port ? p1_we    : p0_we;
    assign sel_addr     = grant_port ? p1_addr  : p0_addr;
    assign sel_wdata    = grant_port ? p1_wdata : p0_wdata;
    assign sel_in_range = addr_in_window(sel_addr, BASE_ADDR, LAST_ADDR);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = sel_in_range ? ST_ISSUE : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory-side address/data only move on an in-range grant so they hold across error responses.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            gnt_port_q  <= 1'b0;
            we_q        <= 1'b0;
            in_range_q  <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else if (take && grant_valid) begin
            gnt_port_q <= grant_port;
            we_q       <= sel_we;
            in_range_q <= sel_in_range;
            if (sel_in_range) begin
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end
        end
    end

    always_comb begin
        mem_en     = (state_q == ST_ISSUE);
        mem_we     = (state_q == ST_ISSUE) && we_q;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        p0_ack     = (state_q == ST_RESP) && !gnt_port_q;
        p1_ack     = (state_q == ST_RESP) &&  gnt_port_q;
        resp_rdata = (in_range_q && !we_q) ? mem_rdata : 32'h0;
        p0_rdata   = p0_ack ? resp_rdata : 32'h0;
        p1_rdata   = p1_ack ? resp_rdata : 32'h0;
        p0_err     = p0_ack && !in_range_q;
        p1_err     = p1_ack && !in_range_q;
    end

endmodule

// File: tb/tb_sram1_arbiter.sv
// tb/tb_sram1_arbiter.sv - directed table-driven bench for sram1_arbiter
module tb_sram1_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem_resp  = 32'h0;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    sram1_arbiter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_ack    (p0_ack),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_ack    (p1_ack),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Registered memory: read data appears the cycle after mem_en.
    always @(posedge clock) begin
        if (mem_en && !mem_we) mem_rdata <= mem_resp;
    end

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memval;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clock);
    endtask

    initial begin
        int          ack_cnt, ack_at, en_cnt, other_cnt;
        logic [31:0] got_rdata, prev_addr;
        logic        got_err, my_ack, oth_ack;
        int          order [$];
        logic [9:0]  en_mask, ack_mask;

        vecs[0] = '{0, 1'b0, 32'h2000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[1] = '{1, 1'b1, 32'h2001_7FFC, 32'h1234_5678, 32'h9999_9999, 32'h0,         1'b0, 3};
        vecs[2] = '{0, 1'b0, 32'h2001_8000, 32'h0,         32'h9999_9999, 32'h0,         1'b1, 2};
        vecs[3] = '{0, 1'b0, 32'h1FFF_FFFC, 32'h0,         32'h9999_9999, 32'h0,         1'b1, 2};
        vecs[4] = '{1, 1'b0, 32'h2000_0000, 32'h0,         32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 3};
        vecs[5] = '{0, 1'b0, 32'h1FFF_FFFF, 32'h0,         32'h9999_9999, 32'h0,         1'b1, 2};
        vecs[6] = '{1, 1'b0, 32'h2001_7FFF, 32'h0,         32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 3};
        vecs[7] = '{1, 1'b1, 32'h2001_8000, 32'h5555_AAAA, 32'h9999_9999, 32'h0,         1'b1, 2};
        vecs[8] = '{0, 1'b1, 32'h2000_1000, 32'hCAFE_0000, 32'h9999_9999, 32'h0,         1'b0, 3};

        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle_cycles(3);

        chk("reset p0_ack",   {31'h0, p0_ack}, 32'h0);
        chk("reset p1_ack",   {31'h0, p1_ack}, 32'h0);
        chk("reset errs",     {30'h0, p1_err, p0_err}, 32'h0);
        chk("reset p0_rdata", p0_rdata, 32'h0);
        chk("reset p1_rdata", p1_rdata, 32'h0);
        chk("reset mem_en",   {30'h0, mem_we, mem_en}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);

        // Simultaneous requests right after reset, both held: expect p0,p1,p0,p1.
        reset_n  = 1'b1;
        mem_resp = 32'h1111_2222;
        drive(0, 1'b1, 1'b0, 32'h2000_0100, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h2000_0200, 32'h0);
        en_cnt = 0;
        for (int s = 1; s <= 12; s++) begin
            @(posedge clock); @(negedge clock);
            if (mem_en && en_cnt == 0) chk("contention first mem_addr", mem_addr, 32'h2000_0100);
            if (mem_en) en_cnt++;
            if (p0_ack) order.push_back(0);
            if (p1_ack) order.push_back(1);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("contention ack count", order.size(), 4);
        chk("contention mem_en count", en_cnt, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < order.size()) chk($sformatf("contention order[%0d]", k), order[k], k % 2);
        end
        idle_cycles(2);

        for (int i = 0; i < 9; i++) begin
            mem_resp  = vecs[i].memval;
            prev_addr = mem_addr;
            drive(vecs[i].port, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            ack_cnt = 0; ack_at = -1; en_cnt = 0; other_cnt = 0;
            got_rdata = 32'h0; got_err = 1'b0;
            for (int s = 1; s <= 5; s++) begin
                @(posedge clock); @(negedge clock);
                my_ack  = (vecs[i].port == 0) ? p0_ack : p1_ack;
                oth_ack = (vecs[i].port == 0) ? p1_ack : p0_ack;
                if (mem_en) begin
                    en_cnt++;
                    chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].addr);
                    chk($sformatf("vec%0d mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].we});
                    if (vecs[i].we) chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
                end
                if (my_ack) begin
                    ack_cnt++;
                    if (ack_at < 0) begin
                        ack_at    = s;
                        got_rdata = (vecs[i].port == 0) ? p0_rdata : p1_rdata;
                        got_err   = (vecs[i].port == 0) ? p0_err   : p1_err;
                    end
                    drive(vecs[i].port, 1'b0, 1'b0, 32'h0, 32'h0);
                end
                if (oth_ack) other_cnt++;
            end
            drive(vecs[i].port, 1'b0, 1'b0, 32'h0, 32'h0);
            chk($sformatf("vec%0d ack count", i), ack_cnt, 1);
            chk($sformatf("vec%0d latency", i), ack_at + 1, vecs[i].exp_lat);
            chk($sformatf("vec%0d rdata", i), got_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d err", i), {31'h0, got_err}, {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d other ack", i), other_cnt, 0);
            chk($sformatf("vec%0d mem_en count", i), en_cnt, vecs[i].exp_err ? 0 : 1);
            if (vecs[i].exp_err) chk($sformatf("vec%0d mem_addr held", i), mem_addr, prev_addr);
            idle_cycles(1);
        end

        // Back-to-back p0 reads with req held: grants every third cycle, one ack each.
        mem_resp = 32'h3C3C_3C3C;
        drive(0, 1'b1, 1'b0, 32'h2000_0080, 32'h0);
        en_mask = '0; ack_mask = '0;
        for (int s = 1; s <= 9; s++) begin
            @(posedge clock); @(negedge clock);
            en_mask[s]  = mem_en;
            ack_mask[s] = p0_ack;
            if (p0_ack) chk($sformatf("b2b rdata s%0d", s), p0_rdata, 32'h3C3C_3C3C);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("b2b mem_en pattern", {22'h0, en_mask}, 32'h092);
        chk("b2b ack pattern", {22'h0, ack_mask}, 32'h124);
        idle_cycles(2);

        // Reset while in ISSUE: no ack, then the held request is served after release.
        mem_resp = 32'h7777_0001;
        drive(1, 1'b1, 1'b0, 32'h2000_0040, 32'h0);
        @(posedge clock); @(negedge clock);
        chk("rst-issue in ISSUE", {31'h0, mem_en}, 32'h1);
        reset_n = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("rst-issue no ack", {30'h0, p1_ack, p0_ack}, 32'h0);
        chk("rst-issue mem_en low", {31'h0, mem_en}, 32'h0);
        reset_n = 1'b1;
        ack_cnt = 0; ack_at = -1; got_rdata = 32'h0;
        for (int s = 1; s <= 4; s++) begin
            @(posedge clock); @(negedge clock);
            if (p1_ack) begin
                ack_cnt++;
                if (ack_at < 0) begin
                    ack_at    = s;
                    got_rdata = p1_rdata;
                end
                drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst-issue ack count", ack_cnt, 1);
        chk("rst-issue latency", ack_at + 1, 3);
        chk("rst-issue rdata", got_rdata, 32'h7777_0001);

        idle_cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sram1_arbiter.md
SRAM1_ARBITER -- requirements
Module: sram1_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 32'h2000_0000, is the first byte address of the SRAM 1 window.
REQ-002 Parameter LAST_ADDR, default 32'h2001_7FFF, is the last byte address of the SRAM 1 window, inclusive.
REQ-003 clock  in  1  single system clock; all state changes on posedge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 p0_req, p1_req  in  1 each  access request from port 0 (fetch) and port 1 (load/store).
REQ-006 p0_we, p1_we  in  1 each  1 = write, 0 = read.
REQ-007 p0_addr, p1_addr  in  32 each  byte address.
REQ-008 p0_wdata, p1_wdata  in  32 each  write data.
REQ-009 p0_ack, p1_ack  out  1 each  one-cycle completion pulse.
REQ-010 p0_rdata, p1_rdata  out  32 each  read data, valid while the matching ack is high.
REQ-011 p0_err, p1_err  out  1 each  address outside the window, valid while the matching ack is high.
REQ-012 mem_en  out  1  memory access strobe.
REQ-013 mem_we  out  1  memory write enable.
REQ-014 mem_addr  out  32  memory address.
REQ-015 mem_wdata  out  32  memory write data.
REQ-016 mem_rdata  in  32  memory read data, registered by the memory, valid the cycle after mem_en.

Function
REQ-017 FSM states: IDLE, ISSUE, RESP; all outputs are driven from registers or decoded directly from state.
REQ-018 IDLE, no request pending: stay in IDLE; mem_en=0; both acks=0.
REQ-019 IDLE with one or both requests: grant one port, latch its we/addr/wdata, and compute in_range = (BASE_ADDR <= addr <= LAST_ADDR), unsigned 32-bit compare.
REQ-020 Contention: round-robin grant to the port not granted last; after reset, port 0 has priority.
REQ-021 The last-grant pointer updates only on a grant.
REQ-022 Grant with in_range=1: go to ISSUE.
REQ-023 Grant with in_range=0: go directly to RESP with err set; no memory access occurs.
REQ-024 ISSUE lasts exactly one cycle: mem_en=1; mem_we, mem_addr and mem_wdata come from the latched values; then go to RESP.
REQ-025 RESP lasts exactly one cycle: the granted port gets ack=1, and the other port's ack stays 0; then go to IDLE.
REQ-026 In RESP, rdata = mem_rdata for an in-range read, and 32'h0 for a write or an error.
REQ-027 In RESP, err = 1 only for an out-of-range grant.
REQ-028 Latency from grant cycle to ack: 3 cycles in range, 2 cycles out of range.
REQ-029 Throughput: at most one access per 3 cycles.
REQ-030 Requester protocol: req and its fields are held stable until the ack cycle.
REQ-031 A req still high in the cycle after ack is a new request.
REQ-032 The ungranted port's req is held and is served after the current transaction; no request is dropped.
REQ-033 Outside ISSUE: mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last values.
REQ-034 Boundary addresses: BASE_ADDR and LAST_ADDR are in range; BASE_ADDR-1 and LAST_ADDR+1 are errors.

Reset
REQ-035 With reset_n low at a posedge: state=IDLE, last-grant pointer = port 1 (so port 0 wins first), mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-036 Under the same reset: all acks=0, errs=0, rdata=0.
REQ-037 Reset during ISSUE or RESP aborts the transaction and produces no ack; the requester re-arbitrates after reset.

Structure
REQ-038 Shared package sram1_arb_pkg holds the state encoding and the SRAM 1 BASE/LAST address constants.
REQ-039 Sub-module rr_arb2 (2-way round-robin grant plus pointer) is instantiated once.

Verification
REQ-040 p0 read 0x2000_0010, memory returns 0xDEAD_BEEF -> mem_en one cycle with mem_we=0 and mem_addr=0x2000_0010; p0_ack 3 cycles after grant with p0_rdata=0xDEAD_BEEF and p0_err=0.
REQ-041 p0 and p1 request in the same cycle right after reset -> p0 served first, then p1; with both held continuously, grants alternate p0,p1,p0,p1.
REQ-042 p1 write 0x2001_7FFC with data 0x1234_5678 -> mem_we=1, mem_wdata=0x1234_5678; p1_ack with rdata=0 and err=0.
REQ-043 p0 read 0x2001_8000, then p0 read 0x1FFF_FFFC -> each acks 2 cycles after grant with err=1, rdata=0, and mem_en never asserted.
REQ-044 reset_n low during ISSUE -> no ack, FSM in IDLE; the request held through reset is served normally after release.
REQ-045 Back-to-back p0 requests with req held high -> the second grant occurs in the IDLE cycle after the ack, and no ack is ever duplicated.
